// File: rtl/pong_timing_pkg.sv
// Shared timing constants and count type for the Pong video timing chain.
// Contents:
//   CNT_W          - width of the H/V counts
//   vcount_t       - 9-bit unsigned count
//   DEF_*          - default line/frame totals and blank/sync boundaries
//   in_window()    - half-open range test lo <= c < hi
package pong_timing_pkg;

    localparam int unsigned CNT_W = 9;

    typedef logic [CNT_W-1:0] vcount_t;

    localparam int unsigned DEF_H_TOTAL      = 455;
    localparam int unsigned DEF_V_TOTAL      = 262;
    localparam int unsigned DEF_H_BLANK_END  = 80;
    localparam int unsigned DEF_H_SYNC_START = 32;
    localparam int unsigned DEF_H_SYNC_END   = 64;
    localparam int unsigned DEF_V_BLANK_END  = 16;
    localparam int unsigned DEF_V_SYNC_START = 4;
    localparam int unsigned DEF_V_SYNC_END   = 8;

    // Half-open window decode used for hsync/vsync.
    function automatic logic in_window(vcount_t c, vcount_t lo, vcount_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/pong_video_timing_if.sv
// Video timing bundle carried from the timing generator to the playfield decodes.
// Signals:
//   hcnt, vcnt       - horizontal / vertical counts
//   hreset, vreset   - last pixel of line / last line of frame
//   hblank, vblank   - blanking flags, active high
//   hsync, vsync     - sync pulses, active high
// Modports: master (timing generator drives), slave (decode logic reads).
interface pong_video_timing_if;
    import pong_timing_pkg::*;

    vcount_t hcnt;
    vcount_t vcnt;
    logic    hreset;
    logic    vreset;
    logic    hblank;
    logic    vblank;
    logic    hsync;
    logic    vsync;

    modport master (
        output hcnt, vcnt, hreset, vreset, hblank, vblank, hsync, vsync
    );

    modport slave (
        input  hcnt, vcnt, hreset, vreset, hblank, vblank, hsync, vsync
    );

endinterface

// File: rtl/pong_modcnt.sv
// Modulo-N counter with enable, terminal-count decode and async active-low clear.
// Ports:
//   i_clk     - clock
//   i_rst_n   - asynchronous active-low clear
//   i_en      - count enable
//   o_cnt     - registered count, 0..N-1
//   o_next_c  - value the count takes on the next enabled edge
//   o_tc_c    - terminal count (count at or above N-1)
module pong_modcnt
    import pong_timing_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_en,
    output vcount_t o_cnt,
    output vcount_t o_next_c,
    output logic    o_tc_c
);

    localparam vcount_t LAST = vcount_t'(N - 1);

    vcount_t r_cnt;

    // Anything at or beyond N-1 is terminal, so a corrupted count recovers on the next enable.
    assign o_tc_c   = (r_cnt >= LAST);
    assign o_next_c = o_tc_c ? '0 : (r_cnt + vcount_t'(1));
    assign o_cnt    = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_next_c;
        end
    end

endmodule

// File: rtl/pong_video_timing.sv
// Synchronous Pong horizontal/vertical timing generator: H/V counts, blanking,
// sync and line/frame reset decodes, all in the clk domain.
// Ports:
//   ce      - pixel clock enable (only when PONG_TIMING_CE_EN is defined)
//   clk     - pixel clock
//   _reset  - asynchronous active-low reset
//   o_vid   - timing bundle (pong_video_timing_if.master)
// Build option: define PONG_TIMING_CE_EN to add the ce port; otherwise the
// block advances on every clk.
module pong_video_timing
    import pong_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned H_BLANK_END  = DEF_H_BLANK_END,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned V_BLANK_END  = DEF_V_BLANK_END,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END
) (
`ifdef PONG_TIMING_CE_EN
    input  logic ce,
`endif
    input  logic clk,
    input  logic _reset,
    pong_video_timing_if.master o_vid
);

    localparam vcount_t HB_END = vcount_t'(H_BLANK_END);
    localparam vcount_t HS_BEG = vcount_t'(H_SYNC_START);
    localparam vcount_t HS_END = vcount_t'(H_SYNC_END);
    localparam vcount_t VB_END = vcount_t'(V_BLANK_END);
    localparam vcount_t VS_BEG = vcount_t'(V_SYNC_START);
    localparam vcount_t VS_END = vcount_t'(V_SYNC_END);

    logic    w_adv;
    logic    w_vadv;
    vcount_t w_hcnt;
    vcount_t w_hnext;
    logic    w_htc;
    vcount_t w_vcnt;
    vcount_t w_vnext;
    logic    w_vtc;

    logic    r_hblank;
    logic    r_vblank;
    logic    r_hsync;
    logic    r_vsync;

`ifdef PONG_TIMING_CE_EN
    assign w_adv = ce;
`else
    assign w_adv = 1'b1;
`endif

    // Lines advance on the pixel step that leaves the last pixel of a line.
    assign w_vadv = w_adv & w_htc;

    pong_modcnt #(.N(H_TOTAL)) u_hcnt (
        .i_clk    (clk),
        .i_rst_n  (_reset),
        .i_en     (w_adv),
        .o_cnt    (w_hcnt),
        .o_next_c (w_hnext),
        .o_tc_c   (w_htc)
    );

    pong_modcnt #(.N(V_TOTAL)) u_vcnt (
        .i_clk    (clk),
        .i_rst_n  (_reset),
        .i_en     (w_vadv),
        .o_cnt    (w_vcnt),
        .o_next_c (w_vnext),
        .o_tc_c   (w_vtc)
    );

    // Blank flags are set/cleared from the counter's next value so they stay
    // aligned with the registered count; sync is a registered window decode.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
        end else begin
            if (w_adv) begin
                if (w_hnext == '0) begin
                    r_hblank <= 1'b1;
                end else if (w_hnext == HB_END) begin
                    r_hblank <= 1'b0;
                end
                r_hsync <= in_window(w_hnext, HS_BEG, HS_END);
            end
            if (w_vadv) begin
                if (w_vnext == '0) begin
                    r_vblank <= 1'b1;
                end else if (w_vnext == VB_END) begin
                    r_vblank <= 1'b0;
                end
                r_vsync <= in_window(w_vnext, VS_BEG, VS_END);
            end
        end
    end

    assign o_vid.hcnt   = w_hcnt;
    assign o_vid.vcnt   = w_vcnt;
    assign o_vid.hreset = w_htc;
    assign o_vid.vreset = w_vtc;
    assign o_vid.hblank = r_hblank;
    assign o_vid.vblank = r_vblank;
    assign o_vid.hsync  = r_hsync;
    assign o_vid.vsync  = r_vsync;

endmodule

// File: tb/tb_pong_video_timing.sv
// Directed bench for pong_video_timing: default-size instance for line,
// vertical, line-period and async-reset behaviour, plus a small-parameter
// instance to walk complete frames including the vertical wrap.
module tb_pong_video_timing;
    import pong_timing_pkg::*;

    localparam int unsigned SH  = 10;
    localparam int unsigned SV  = 6;
    localparam int unsigned SHB = 3;
    localparam int unsigned SHS = 1;
    localparam int unsigned SHE = 2;
    localparam int unsigned SVB = 2;
    localparam int unsigned SVS = 1;
    localparam int unsigned SVE = 2;

    // {hcnt, vcnt, hreset, vreset, hblank, vblank, hsync, vsync}
    localparam logic [23:0] RST_VEC = {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic rst_s_n;
    logic ce;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_video_timing_if vid ();
    pong_video_timing_if vid_s ();

    pong_video_timing u_dut (
`ifdef PONG_TIMING_CE_EN
        .ce     (ce),
`endif
        .clk    (clk),
        ._reset (rst_n),
        .o_vid  (vid)
    );

    pong_video_timing #(
        .H_TOTAL(SH), .V_TOTAL(SV), .H_BLANK_END(SHB), .H_SYNC_START(SHS),
        .H_SYNC_END(SHE), .V_BLANK_END(SVB), .V_SYNC_START(SVS), .V_SYNC_END(SVE)
    ) u_small (
`ifdef PONG_TIMING_CE_EN
        .ce     (ce),
`endif
        .clk    (clk),
        ._reset (rst_s_n),
        .o_vid  (vid_s)
    );

    logic [23:0] got_d;
    logic [23:0] got_s;
    assign got_d = {vid.hcnt, vid.vcnt, vid.hreset, vid.vreset,
                    vid.hblank, vid.vblank, vid.hsync, vid.vsync};
    assign got_s = {vid_s.hcnt, vid_s.vcnt, vid_s.hreset, vid_s.vreset,
                    vid_s.hblank, vid_s.vblank, vid_s.hsync, vid_s.vsync};

    // Reference position counters; flags are derived from ranges below.
    int unsigned e_h, e_v, s_h, s_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_h <= 0;
            e_v <= 0;
        end else if (ce) begin
            if (e_h == DEF_H_TOTAL - 1) begin
                e_h <= 0;
                e_v <= (e_v == DEF_V_TOTAL - 1) ? 0 : e_v + 1;
            end else begin
                e_h <= e_h + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            s_h <= 0;
            s_v <= 0;
        end else if (ce) begin
            if (s_h == SH - 1) begin
                s_h <= 0;
                s_v <= (s_v == SV - 1) ? 0 : s_v + 1;
            end else begin
                s_h <= s_h + 1;
            end
        end
    end

    function automatic logic [23:0] exp_vec(int unsigned h, int unsigned v,
                                            int unsigned ht, int unsigned vt,
                                            int unsigned hb, int unsigned hs, int unsigned he,
                                            int unsigned vb, int unsigned vs, int unsigned ve);
        return {9'(h), 9'(v), (h == ht - 1), (v == vt - 1), (h < hb), (v < vb),
                (h >= hs && h < he), (v >= vs && v < ve)};
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        ce      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (got_d !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_default: got %h expected %h", got_d, RST_VEC);
        end
        n_vec++;
        if (got_s !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_small: got %h expected %h", got_s, RST_VEC);
        end
    endtask

    task automatic test_h_line();
        logic [23:0] exp;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3 * 455; i++) begin
            @(posedge clk);
            #1;
            exp = exp_vec(e_h, e_v, DEF_H_TOTAL, DEF_V_TOTAL, DEF_H_BLANK_END,
                          DEF_H_SYNC_START, DEF_H_SYNC_END, DEF_V_BLANK_END,
                          DEF_V_SYNC_START, DEF_V_SYNC_END);
            n_vec++;
            if (got_d !== exp) begin
                n_err++;
                $display("FAIL h_line cyc %0d: got %h expected %h", i, got_d, exp);
            end
            if (i == 454) begin
                n_vec++;
                if ({vid.hcnt, vid.hreset} !== {9'd454, 1'b1}) begin
                    n_err++;
                    $display("FAIL h_last: got hcnt %0d hreset %b expected 454 1",
                             vid.hcnt, vid.hreset);
                end
            end
            if (i == 455) begin
                n_vec++;
                if ({vid.hcnt, vid.vcnt, vid.hblank} !== {9'd0, 9'd1, 1'b1}) begin
                    n_err++;
                    $display("FAIL h_wrap: got hcnt %0d vcnt %0d hblank %b expected 0 1 1",
                             vid.hcnt, vid.vcnt, vid.hblank);
                end
            end
        end
    endtask

    task automatic test_vertical();
        logic [23:0] exp;
        for (int i = 0; i < 17 * 455; i++) begin
            @(posedge clk);
            #1;
            exp = exp_vec(e_h, e_v, DEF_H_TOTAL, DEF_V_TOTAL, DEF_H_BLANK_END,
                          DEF_H_SYNC_START, DEF_H_SYNC_END, DEF_V_BLANK_END,
                          DEF_V_SYNC_START, DEF_V_SYNC_END);
            n_vec++;
            if (got_d !== exp) begin
                n_err++;
                $display("FAIL vertical cyc %0d: got %h expected %h", i, got_d, exp);
            end
        end
        n_vec++;
        if ({vid.hcnt, vid.vcnt, vid.vblank, vid.vsync} !== {9'd0, 9'd20, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL vertical_end: got hcnt %0d vcnt %0d vblank %b vsync %b expected 0 20 0 0",
                     vid.hcnt, vid.vcnt, vid.vblank, vid.vsync);
        end
    endtask

    task automatic test_frame();
        logic [23:0] exp;
        @(negedge clk);
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        for (int i = 1; i <= 2 * SH * SV; i++) begin
            @(posedge clk);
            #1;
            exp = exp_vec(s_h, s_v, SH, SV, SHB, SHS, SHE, SVB, SVS, SVE);
            n_vec++;
            if (got_s !== exp) begin
                n_err++;
                $display("FAIL frame cyc %0d: got %h expected %h", i, got_s, exp);
            end
            if (i == 59) begin
                n_vec++;
                if ({vid_s.hcnt, vid_s.vcnt, vid_s.hreset, vid_s.vreset} !==
                    {9'd9, 9'd5, 1'b1, 1'b1}) begin
                    n_err++;
                    $display("FAIL frame_last: got %0d %0d %b %b expected 9 5 1 1",
                             vid_s.hcnt, vid_s.vcnt, vid_s.hreset, vid_s.vreset);
                end
            end
            if (i == 60) begin
                n_vec++;
                if ({vid_s.hcnt, vid_s.vcnt, vid_s.hblank, vid_s.vblank} !==
                    {9'd0, 9'd0, 1'b1, 1'b1}) begin
                    n_err++;
                    $display("FAIL frame_wrap: got %0d %0d %b %b expected 0 0 1 1",
                             vid_s.hcnt, vid_s.vcnt, vid_s.hblank, vid_s.vblank);
                end
            end
        end
    endtask

`ifdef PONG_TIMING_CE_EN
    task automatic test_ce_line();
        logic [23:0] exp;
        int unsigned h0, v0;
        @(negedge clk);
        h0 = e_h;
        v0 = e_v;
        for (int i = 0; i < 4 * 455; i++) begin
            ce = (i % 4 == 0);
            @(posedge clk);
            #1;
            exp = exp_vec(e_h, e_v, DEF_H_TOTAL, DEF_V_TOTAL, DEF_H_BLANK_END,
                          DEF_H_SYNC_START, DEF_H_SYNC_END, DEF_V_BLANK_END,
                          DEF_V_SYNC_START, DEF_V_SYNC_END);
            n_vec++;
            if (got_d !== exp) begin
                n_err++;
                $display("FAIL ce_line cyc %0d: got %h expected %h", i, got_d, exp);
            end
            @(negedge clk);
        end
        ce = 1'b1;
        n_vec++;
        if ({vid.hcnt, vid.vcnt} !== {9'(h0), 9'(v0 + 1)}) begin
            n_err++;
            $display("FAIL ce_period: got hcnt %0d vcnt %0d expected %0d %0d",
                     vid.hcnt, vid.vcnt, h0, v0 + 1);
        end
    endtask
`else
    task automatic test_no_ce_line();
        int unsigned h0, v0;
        h0 = e_h;
        v0 = e_v;
        repeat (455) @(posedge clk);
        #1;
        n_vec++;
        if ({vid.hcnt, vid.vcnt} !== {9'(h0), 9'(v0 + 1)}) begin
            n_err++;
            $display("FAIL line_period: got hcnt %0d vcnt %0d expected %0d %0d",
                     vid.hcnt, vid.vcnt, h0, v0 + 1);
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [23:0] exp;
        bit found = 0;
        for (int i = 0; i < 60000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (e_h == 200 && e_v == 100) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_200_100: model position %0d %0d expected 200 100", e_h, e_v);
        end
        exp = {9'd200, 9'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (got_d !== exp) begin
            n_err++;
            $display("FAIL pre_reset: got %h expected %h", got_d, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (got_d !== RST_VEC) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", got_d, RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp = {9'd1, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if (got_d !== exp) begin
            n_err++;
            $display("FAIL restart: got %h expected %h", got_d, exp);
        end
    endtask

    initial begin
        test_reset();
        test_h_line();
        test_vertical();
        test_frame();
`ifdef PONG_TIMING_CE_EN
        test_ce_line();
`else
        test_no_ce_line();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
